// File: rtl/xm_mem_unit.sv
// -----------------------------------------------------------------------------
// xm_mem_unit
//
// Bridges a simple controller-side memory request (byte or word, read or write)
// onto an external request/acknowledge bus with byte-lane enables. The unit
// keeps one access outstanding at a time. A word access to an odd address is
// rejected with a one-cycle fault pulse and never reaches the bus.
//
// Optional build feature:
//   XM_MEM_TIMEOUT_EN  When defined, a bus request left without busAck_i for
//                      TIMEOUT cycles is abandoned with a fault pulse. When
//                      undefined, the unit waits on busAck_i indefinitely.
//
// Parameters:
//   WORD     data/address width in bits (the lane logic assumes 16)
//   TIMEOUT  maximum bus-wait cycles before a fault (timeout build only)
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   arst_i       synchronous active-high reset
//   memEn_i      controller access request, sampled in IDLE
//   memRW_i      0 = read, 1 = write
//   byteOp_i     1 = byte access, 0 = word access
//   adr_i        byte address
//   wrData_i     write data
//   rdData_o     registered read data, updated only by a completed read
//   memBusy_o    access in progress (includes the request cycle)
//   memFault_o   one-cycle fault pulse (misaligned word or bus timeout)
//   busReq_o     external request, held high until ack (or timeout)
//   busWe_o      external write enable
//   busAdr_o     word-aligned external address
//   busBe_o      byte-lane enables, bit 0 = [7:0], bit 1 = [15:8]
//   busWrData_o  external write data
//   busRdData_i  external read data
//   busAck_i     external transfer complete
// -----------------------------------------------------------------------------
module xm_mem_unit #(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] adr_i,
  input  logic [WORD-1:0] wrData_i,
  output logic [WORD-1:0] rdData_o,
  output logic            memBusy_o,
  output logic            memFault_o,
  output logic            busReq_o,
  output logic            busWe_o,
  output logic [WORD-1:0] busAdr_o,
  output logic [1:0]      busBe_o,
  output logic [WORD-1:0] busWrData_o,
  input  logic [WORD-1:0] busRdData_i,
  input  logic            busAck_i
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;      // legal access taken in IDLE this cycle
  logic misaligned;  // word access to an odd address, rejected
  logic done;        // bus acknowledged the outstanding access
  logic timed_out;   // outstanding access abandoned for lack of ack

`ifdef XM_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    misaligned = 1'b0;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        // busAck_i is deliberately not looked at here.
        if (memEn_i) begin
          if (!byteOp_i && adr_i[0]) begin
            misaligned = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // memEn_i is deliberately not looked at here. An ack on the same edge
        // as the timeout takes priority, so the access completes normally.
        if (busAck_i) begin
          done       = 1'b1;
          state_next = IDLE;
        end
`ifdef XM_MEM_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Busy covers the request cycle itself so the controller sees it at once.
  assign memBusy_o = (state == REQ) || ((state == IDLE) && memEn_i);

  // ---------------------------------------------------------------------------
  // Bus-side registers and read data
  // ---------------------------------------------------------------------------
  // The latched busWe_o/busBe_o double as the record of what the outstanding
  // access was: a read has busWe_o low, a byte access has a single lane
  // enabled, and busBe_o[1] names the upper lane.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      busReq_o    <= 1'b0;
      busWe_o     <= 1'b0;
      busBe_o     <= 2'b00;
      busAdr_o    <= '0;
      busWrData_o <= '0;
      rdData_o    <= '0;
      memFault_o  <= 1'b0;
    end else begin
      memFault_o <= misaligned | timed_out;

      if (accept) begin
        busReq_o <= 1'b1;
        busWe_o  <= memRW_i;
        busAdr_o <= {adr_i[WORD-1:1], 1'b0};
        if (!byteOp_i) begin
          busBe_o <= 2'b11;
        end else if (adr_i[0]) begin
          busBe_o <= 2'b10;
        end else begin
          busBe_o <= 2'b01;
        end
        // A byte write drives its byte on every lane; the enables pick one.
        busWrData_o <= byteOp_i ? {(WORD/8){wrData_i[7:0]}} : wrData_i;
      end

      if (done || timed_out) begin
        busReq_o <= 1'b0;
      end

      if (done && !busWe_o) begin
        if (busBe_o == 2'b11) begin
          rdData_o <= busRdData_i;
        end else if (busBe_o[1]) begin
          rdData_o <= WORD'(busRdData_i[15:8]);
        end else begin
          rdData_o <= WORD'(busRdData_i[7:0]);
        end
      end
    end
  end

`ifdef XM_MEM_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Bus-wait counter: counts REQ cycles that end without an ack, and restarts
  // from zero whenever the unit is not waiting.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      tmo_cnt <= '0;
    end else if ((state == REQ) && !busAck_i && !timed_out) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

endmodule

// File: doc/xm_mem_unit.md
XM_MEM_UNIT -- requirements
Module: xm_mem_unit

Interface
REQ-001 Parameter WORD, default 16, SHALL set data and address width in bits.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum bus-wait cycles before a fault (used only with XM_MEM_TIMEOUT_EN).
REQ-003 clk_i  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 arst_i  in  1  reset, synchronous, active-high.
REQ-005 memEn_i  in  1  controller access request, sampled in IDLE.
REQ-006 memRW_i  in  1  0=read, 1=write.
REQ-007 byteOp_i  in  1  1=byte access, 0=word access.
REQ-008 adr_i  in  WORD  byte address.
REQ-009 wrData_i  in  WORD  write data.
REQ-010 rdData_o  out  WORD  registered read data.
REQ-011 memBusy_o  out  1  access in progress, to the controller.
REQ-012 memFault_o  out  1  one-cycle fault pulse.
REQ-013 busReq_o / busWe_o  out  1 each  external request / write-enable.
REQ-014 busAdr_o  out  WORD  word-aligned address, bit 0 always 0.
REQ-015 busBe_o  out  2  byte-lane enables; bit 0 selects [7:0], bit 1 selects [15:8].
REQ-016 busWrData_o  out  WORD; busRdData_i  in  WORD; busAck_i  in  1  transfer complete.

Function
REQ-017 The FSM SHALL have states IDLE and REQ, and supports one outstanding access.
REQ-018 In IDLE, a legal access with memEn_i=1 at an edge SHALL latch adr/data/control, set busReq_o=1 and enter REQ.
REQ-019 memBusy_o SHALL equal (state==REQ) OR (state==IDLE AND memEn_i), so it is high in the request cycle.
REQ-020 In REQ, busAck_i=1 at an edge SHALL capture read data (reads only), clear busReq_o and return to IDLE; minimum latency is 2 edges.
REQ-021 busAck_i SHALL be ignored in IDLE; memEn_i SHALL be ignored in REQ.
REQ-022 Bus outputs SHALL hold stable for the whole of REQ.
REQ-023 A word access drives busBe_o=11; byte access: adr_i[0]=0 gives 01, adr_i[0]=1 gives 10.
REQ-024 A byte write SHALL place wrData_i[7:0] on both lanes of busWrData_o.
REQ-025 A byte read SHALL return the selected lane in rdData_o[7:0], with [15:8] zero.
REQ-026 A word read SHALL return busRdData_i unchanged.
REQ-027 A word access with adr_i[0]=1 SHALL issue no bus cycle, pulse memFault_o for one cycle and stay in IDLE.
REQ-028 rdData_o SHALL change only on a successful read completion.
REQ-029 memFault_o SHALL be 0 except during a fault pulse.

Reset
REQ-030 While arst_i=1 at an edge: state=IDLE, busReq_o=0, busWe_o=0, busBe_o=00, busAdr_o=0, busWrData_o=0, rdData_o=0, memFault_o=0, timeout counter=0.
REQ-031 Reset during REQ SHALL abandon the access, and busReq_o SHALL be 0 after that edge.

Configuration
REQ-032 With XM_MEM_TIMEOUT_EN defined, a counter SHALL count REQ cycles without ack.
- On reaching TIMEOUT, the unit SHALL clear busReq_o, pulse memFault_o, return to IDLE and leave rdData_o unchanged.
- An ack arriving on the same edge as the timeout SHALL win, with no fault.
REQ-033 Without XM_MEM_TIMEOUT_EN, REQ SHALL wait indefinitely for busAck_i and the counter SHALL not exist.

Verification
REQ-034 Word read adr=0x0010, ack after 3 cycles with busRdData_i=0xBEEF -> busBe_o=11, memBusy_o high 4 cycles, rdData_o=0xBEEF.
REQ-035 Byte read adr=0x0021, busRdData_i=0x12AB -> busAdr_o=0x0020, busBe_o=10, rdData_o=0x0012.
REQ-036 Byte write adr=0x0030, wrData_i=0x00C5 -> busWe_o=1, busBe_o=01, busWrData_o=0xC5C5.
REQ-037 Word write adr=0x0013 -> no busReq_o, memFault_o high exactly 1 cycle.
REQ-038 XM_MEM_TIMEOUT_EN with TIMEOUT=15 and no ack -> fault after 15 REQ cycles, busReq_o=0; reset asserted mid-REQ -> IDLE next edge.
